// File: rtl/ad9361_framer_pkg.sv
// Shared types and constants for the AD9361 AXI-stream framer.
// The optional trailer beat is enabled with the AD9361_FRAMER_TRAILER_EN macro.
package ad9361_framer_pkg;

  localparam int unsigned AxisDataWidth = 128;

  // Header field placement: {magic, seq_num, samp_idx}
  localparam int unsigned MagicLsb   = 96;
  localparam int unsigned MagicWidth = 32;
  localparam int unsigned SeqLsb     = 64;
  localparam int unsigned SeqWidth   = 32;
  localparam int unsigned IdxLsb     = 0;
  localparam int unsigned IdxWidth   = 64;

  localparam logic [MagicWidth-1:0] DefaultHeaderMagic = 32'hAD93_6100;

  typedef enum logic [1:0] {StHeader, StPayload, StTrailer} state_e;

  function automatic logic [AxisDataWidth-1:0] pack_header(
    input logic [MagicWidth-1:0] magic,
    input logic [SeqWidth-1:0]   seq,
    input logic [IdxWidth-1:0]   idx
  );
    logic [AxisDataWidth-1:0] h;
    h = '0;
    h[MagicLsb +: MagicWidth] = magic;
    h[SeqLsb +: SeqWidth]     = seq;
    h[IdxLsb +: IdxWidth]     = idx;
    return h;
  endfunction

endpackage

// File: rtl/ad9361_axis_out_reg.sv
// Single registered AXI-stream output slot. A load may coincide with the
// downstream accept of the previous beat, giving full throughput.
module ad9361_axis_out_reg
  import ad9361_framer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [AxisDataWidth-1:0] data_i,
  input  logic                     last_i,
  input  logic                     tready_i,
  output logic                     tvalid_o,
  output logic                     tlast_o,
  output logic [AxisDataWidth-1:0] tdata_o,
  output logic                     load_ok_o
);

  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic [AxisDataWidth-1:0] data_q, data_d;

  // Slot is free when empty or being drained this cycle.
  assign load_ok_o = !valid_q || tready_i;

  // Next slot contents: new beat replaces, accept empties, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
      data_d  = data_i;
    end else if (tready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign tvalid_o = valid_q;
  assign tlast_o  = last_q;
  assign tdata_o  = data_q;

endmodule

// File: rtl/ad9361_axis_framer.sv
// Frames the packed dual-AD9361 I/Q stream into packets of one header beat
// followed by PACKET_BEATS payload beats. Define AD9361_FRAMER_TRAILER_EN to
// append a trailer beat holding the XOR of the packet's payload beats.
module ad9361_axis_framer
  import ad9361_framer_pkg::*;
#(
  parameter int unsigned       PACKET_BEATS   = 256,
  parameter logic [31:0]       HEADER_MAGIC   = DefaultHeaderMagic,
  parameter int unsigned       BEAT_CNT_WIDTH = $clog2(PACKET_BEATS) + 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [AxisDataWidth-1:0] s_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [AxisDataWidth-1:0] m_axis_tdata,
  output logic                     busy
);

  localparam logic [BEAT_CNT_WIDTH-1:0] LastBeat = BEAT_CNT_WIDTH'(PACKET_BEATS - 1);

  state_e                    state_q, state_d;
  logic [SeqWidth-1:0]       seq_q, seq_d;
  logic [IdxWidth-1:0]       samp_idx_q, samp_idx_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                      busy_q, busy_d;
`ifdef AD9361_FRAMER_TRAILER_EN
  logic [AxisDataWidth-1:0]  acc_q, acc_d;
`endif

  logic                     load_ok;
  logic                     load;
  logic                     load_last;
  logic [AxisDataWidth-1:0] load_data;
  logic                     s_hs;

  assign s_axis_tready = (state_q == StPayload) && load_ok;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  // Packet sequencing: decide what enters the output slot this cycle.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    samp_idx_d = samp_idx_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
`ifdef AD9361_FRAMER_TRAILER_EN
    acc_d      = acc_q;
`endif
    load       = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;

    // Clear on the tlast handshake; a header load below may re-set it.
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StHeader: begin
        // Only frame when a payload beat is already waiting upstream.
        if (enable && s_axis_tvalid && load_ok) begin
          load       = 1'b1;
          load_data  = pack_header(HEADER_MAGIC, seq_q, samp_idx_q);
          busy_d     = 1'b1;
          beat_cnt_d = '0;
`ifdef AD9361_FRAMER_TRAILER_EN
          acc_d      = '0;
`endif
          state_d    = StPayload;
        end
      end
      StPayload: begin
        if (s_hs) begin
          load       = 1'b1;
          load_data  = s_axis_tdata;
          samp_idx_d = samp_idx_q + IdxWidth'(1);
          beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
`ifdef AD9361_FRAMER_TRAILER_EN
          acc_d      = acc_q ^ s_axis_tdata;
`endif
          if (beat_cnt_q == LastBeat) begin
            seq_d = seq_q + SeqWidth'(1);
`ifdef AD9361_FRAMER_TRAILER_EN
            state_d = StTrailer;
`else
            load_last = 1'b1;
            state_d   = StHeader;
`endif
          end
        end
      end
      StTrailer: begin
`ifdef AD9361_FRAMER_TRAILER_EN
        if (load_ok) begin
          load      = 1'b1;
          load_data = acc_q;
          load_last = 1'b1;
          state_d   = StHeader;
        end
`else
        state_d = StHeader;
`endif
      end
      default: state_d = StHeader;
    endcase
  end

  // Framer state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StHeader;
      seq_q      <= '0;
      samp_idx_q <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
`ifdef AD9361_FRAMER_TRAILER_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      samp_idx_q <= samp_idx_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
`ifdef AD9361_FRAMER_TRAILER_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign busy = busy_q;

  ad9361_axis_out_reg u_out_reg (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .load_i    (load),
    .data_i    (load_data),
    .last_i    (load_last),
    .tready_i  (m_axis_tready),
    .tvalid_o  (m_axis_tvalid),
    .tlast_o   (m_axis_tlast),
    .tdata_o   (m_axis_tdata),
    .load_ok_o (load_ok)
  );

endmodule

// File: tb/tb_ad9361_axis_framer.sv
// Scoreboard bench for ad9361_axis_framer with PACKET_BEATS=4.
module tb_ad9361_axis_framer;

  localparam int unsigned PB = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata = '0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [127:0] m_axis_tdata;
  logic         busy;

  always #5 clk = ~clk;

  ad9361_axis_framer #(
    .PACKET_BEATS (PB)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .busy          (busy)
  );

  typedef struct packed {
    logic         last;
    logic [127:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready

  // Reference model: packet position, sequence number and global sample index.
  logic [31:0]  m_seq;
  logic [63:0]  m_idx;
  int           m_pos;
  logic [127:0] m_acc;

  function automatic void model_reset();
    m_seq = '0;
    m_idx = '0;
    m_pos = 0;
    m_acc = '0;
  endfunction

  function automatic void model_push(input logic [127:0] d);
    beat_t b;
    if (m_pos == 0) begin
      b.last = 1'b0;
      b.data = {32'hAD93_6100, m_seq, m_idx};
      exp_q.push_back(b);
      m_acc = '0;
    end
    m_acc = m_acc ^ d;
    b.data = d;
`ifdef AD9361_FRAMER_TRAILER_EN
    b.last = 1'b0;
`else
    b.last = (m_pos == PB - 1);
`endif
    exp_q.push_back(b);
    m_idx = m_idx + 64'd1;
    m_pos = m_pos + 1;
    if (m_pos == PB) begin
`ifdef AD9361_FRAMER_TRAILER_EN
      b.last = 1'b1;
      b.data = m_acc;
      exp_q.push_back(b);
`endif
      m_seq = m_seq + 32'd1;
      m_pos = 0;
    end
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every downstream handshake.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic         pl = 1'b0;
  logic [127:0] pd = '0;

  always @(negedge clk) begin
    beat_t e;
    if (!resetn) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 128'(m_axis_tvalid), 128'd1);
        check("hold_data", m_axis_tdata, pd);
        check("hold_last", 128'(m_axis_tlast), 128'(pl));
      end
      if (m_axis_tvalid) check("busy_with_valid", 128'(busy), 128'd1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual %h last %0b, required no beat",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e.data);
          check("beat_last", 128'(m_axis_tlast), 128'(e.last));
        end
      end
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
  end

  // Offer one upstream beat; returns the number of cycles it waited for ready.
  task automatic send_beat(input logic [127:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    model_push(d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual no accept in 2000 cycles, required accept of %h", d);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_axis_tvalid) done = 1'b1;
    end
    check(name, 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int w;
    model_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("rst_tlast", 128'(m_axis_tlast), 128'd0);
    check("rst_tdata", m_axis_tdata, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_s_tready", 128'(s_axis_tready), 128'd0);
    resetn = 1'b1;
    enable = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Continuous beats 1..8, always ready: one ready-low cycle per packet.
    for (int i = 1; i <= 8; i++) begin
      send_beat(128'(i), w);
      check("t1_ready_wait", 128'(w), ((i - 1) % PB == 0) ? 128'd1 : 128'd0);
    end
    wait_drain("t1_drain");
    check("t1_busy_idle", 128'(busy), 128'd0);

    // Reset in the middle of a payload.
    send_beat(128'd9, w);
    send_beat(128'd10, w);
    resetn = 1'b0;
    #1;
    check("t2_rst_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("t2_rst_busy", 128'(busy), 128'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Enable dropped after the 2nd payload beat; packet still completes.
    send_beat(128'd1, w);
    send_beat(128'd2, w);
    enable = 1'b0;
    send_beat(128'd3, w);
    send_beat(128'd4, w);
    wait_drain("t3_drain");
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 128'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_no_ready", 128'(s_axis_tready), 128'd0);
      check("t3_no_header", 128'(m_axis_tvalid), 128'd0);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    for (int i = 5; i <= 8; i++) send_beat(128'(i), w);
    wait_drain("t3_drain2");

    // Random downstream stalls and upstream bubbles.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_beat({$urandom, $urandom, $urandom, $urandom}, w);
    end
    wait_drain("t4_drain");
    rdy_mode = 0;

    // Counter wrap-around from preloaded values.
    enable = 1'b0;
    @(posedge clk);
    #1;
    force dut.seq_q = 32'hFFFF_FFFF;
    force dut.samp_idx_q = 64'hFFFF_FFFF_FFFF_FFFE;
    repeat (2) @(posedge clk);
    #1;
    release dut.seq_q;
    release dut.samp_idx_q;
    m_seq = 32'hFFFF_FFFF;
    m_idx = 64'hFFFF_FFFF_FFFF_FFFE;
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send_beat(128'(i + 100), w);
      check("t5_ready_wait", 128'(w), ((i - 1) % PB == 0) ? 128'd1 : 128'd0);
    end
    wait_drain("t5_drain");

`ifdef AD9361_FRAMER_TRAILER_EN
    // Trailer carries the XOR of the payload beats.
    send_beat(128'd1, w);
    send_beat(128'd2, w);
    send_beat(128'd4, w);
    send_beat(128'd8, w);
    wait_drain("t6_drain");
`endif

    check("end_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad9361_axis_framer.md
Name: ad9361_axis_framer

Overview:
- Consumes the 128-bit AXI-stream of packed dual-AD9361 I/Q beats produced by the dual receive path.
- Frames the stream into fixed-length packets for the host link. Each packet is one header beat (magic word, sequence number, sample index) followed by PACKET_BEATS payload beats.
- Sits between the receive path's AXI-stream output and the host-side DMA/USB FIFO, all in the m_axis_clk domain.

Parameters:
- PACKET_BEATS, 256, payload beats per packet; legal range 1..65536.
- HEADER_MAGIC, 32'hAD93_6100, constant placed in header bits [127:96].
- BEAT_CNT_WIDTH, $clog2(PACKET_BEATS)+1, width of the payload beat counter (derived; not to be overridden).

Ports:
- clk  input  1  single clock; connected to m_axis_clk of the receive path.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  packet-start gate; sampled only at packet boundaries.
- s_axis_tvalid  input  1  upstream beat valid.
- s_axis_tready  output  1  upstream beat accepted.
- s_axis_tdata  input  128  packed I/Q beat.
- m_axis_tvalid  output  1  framed beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  last beat of packet.
- m_axis_tdata  output  128  header or payload beat.
- busy  output  1  high from header issue until the last beat of the packet is accepted downstream.

Behaviour:
- Reset (async assert, synchronous deassert handled externally):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0.
  - seq_num=0, samp_idx=0 (64-bit), beat_cnt=0, state=HEADER.
- Output stage is a single registered slot:
  - load_ok = !m_axis_tvalid || m_axis_tready.
  - Accepted beats appear on m_axis exactly 1 cycle later.
  - Once valid, m_axis_tdata and m_axis_tlast are held stable until accepted.
- FSM:
  - HEADER:
    - s_axis_tready=0.
    - Move when enable && s_axis_tvalid && load_ok: load header {HEADER_MAGIC, seq_num, samp_idx}, tlast=0, busy=1, beat_cnt=0, go to PAYLOAD.
    - No header is ever issued without a pending upstream beat, so no stale headers.
  - PAYLOAD:
    - s_axis_tready = load_ok.
    - On each accept: load s_axis_tdata, samp_idx+=1, beat_cnt+=1.
    - tlast=1 when beat_cnt==PACKET_BEATS-1.
    - On that last accept: seq_num+=1, go to HEADER (or TRAILER if the optional feature is compiled in).
- busy clears in the cycle after the tlast beat handshakes downstream. It may overlap with the next header load.
- enable:
  - Deassert mid-packet: the current packet completes normally.
  - No new header is issued while enable=0; s_axis_tready stays 0 in HEADER.
  - Re-assert: next header carries the continuing seq_num and samp_idx.
- Header layout: [127:96] magic, [95:64] seq_num, [63:0] samp_idx = global index of the first payload beat of the packet.
- Wrap-around:
  - seq_num wraps 2^32-1 -> 0.
  - samp_idx wraps 2^64-1 -> 0.
  - Neither wrap causes a stall.
- PACKET_BEATS=1: every payload beat carries tlast=1.
- Downstream stall: output slot holds; upstream is back-pressured. No data is dropped and no beat is duplicated.
- Simultaneous downstream accept and new load: the new beat replaces the old one in the same cycle, sustaining full throughput in PAYLOAD.
- Throughput: PACKET_BEATS/(PACKET_BEATS+1) of line rate.

Optional Feature:
- Macro: AD9361_FRAMER_TRAILER_EN.
- Defined:
  - FSM gains a TRAILER state after PAYLOAD.
  - Trailer beat = running 128-bit XOR of all payload beats of the packet (accumulator cleared at header load).
  - tlast moves from the last payload beat to the trailer beat.
  - s_axis_tready=0 in TRAILER.
  - Trailer is loaded when load_ok, then FSM returns to HEADER.
- Undefined: no TRAILER state, no accumulator; tlast is on the last payload beat.

Decomposition:
- Package ad9361_framer_pkg:
  - state enum (HEADER, PAYLOAD, TRAILER).
  - header field offsets/widths.
  - default HEADER_MAGIC.
  - AXIS data width constant 128.
- One sub-module: ad9361_axis_out_reg, the registered output slot with tvalid/tready/tlast/tdata and load_ok.

Test Plan:
- PACKET_BEATS=4, continuous upstream beats 1..8, tready=1 -> output H(seq0,idx0),1,2,3,4(tlast), H(seq1,idx4),5,6,7,8(tlast); s_axis_tready low exactly 1 cycle per packet.
- Random m_axis_tready (50%) with 1000 beats -> payload order and contents identical to input; no drops or duplicates; tdata stable while stalled.
- enable dropped after 2nd payload beat of packet 0 -> packet 0 completes with 4 beats and tlast; no header while enable=0; on re-enable, header shows seq1, idx4.
- Preload seq_num=32'hFFFF_FFFF, samp_idx=64'hFFFF_FFFF_FFFF_FFFE (force) -> header carries those values; next header shows seq0, idx 2 (PACKET_BEATS=4).
- resetn asserted mid-payload -> m_axis_tvalid=0 immediately; after release, first output is header seq0, idx0.
- With AD9361_FRAMER_TRAILER_EN, payload beats 1,2,4,8 -> trailer beat 15 with tlast; payload beat 8 has tlast=0.
